// File: rtl/fp_mul_writeback.sv
// Writeback stage behind the single-precision multiplier: a small result FIFO with
// NaN canonicalisation on enqueue, a valid/ready writeback port and sticky fflags.
module fp_mul_writeback #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 5,
  parameter int CANON_NAN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       in_flag_invalid,
  input  logic                       in_flag_overflow,
  input  logic                       in_flag_underflow,
  input  logic                       in_flag_inexact,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [4:0]                 out_flags,
  output logic [4:0]                 fflags,
  input  logic                       fflags_wr_en,
  input  logic [4:0]                 fflags_wr_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Any NaN collapses to the positive quiet NaN; infinities have a zero mantissa and pass.
  function automatic logic [31:0] canon_result(input logic [31:0] r);
    logic [31:0] res;
    if ((CANON_NAN != 0) && (r[30:23] == 8'hFF) && (r[22:0] != 23'd0)) begin
      res = QNAN;
    end else begin
      res = r;
    end
    return res;
  endfunction

  logic [31:0]      res_q   [DEPTH];
  logic [31:0]      res_d   [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [4:0]       flg_q   [DEPTH];
  logic [4:0]       flg_d   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             push_s, pop_s, out_valid_s;
  logic [4:0]       head_flags_s;

  assign out_valid_s  = (count_q != {CW{1'b0}});
  assign in_ready     = !flush && (count_q < FULL_CNT);
  assign push_s       = in_valid && in_ready;
  assign pop_s        = out_valid_s && out_ready;
  assign head_flags_s = out_valid_s ? flg_q[rd_ptr_q] : 5'b00000;

  assign out_valid  = out_valid_s;
  assign out_result = out_valid_s ? res_q[rd_ptr_q] : 32'h0000_0000;
  assign out_tag    = out_valid_s ? tag_q[rd_ptr_q] : {TAG_W{1'b0}};
  assign out_flags  = head_flags_s;
  assign fflags     = fflags_q;
  assign count      = count_q;

  // Next-state for storage, pointers, occupancy and the sticky flags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      res_d[i] = res_q[i];
      tag_d[i] = tag_q[i];
      flg_d[i] = flg_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      res_d[wr_ptr_q] = canon_result(in_result);
      tag_d[wr_ptr_q] = in_tag;
      flg_d[wr_ptr_q] = {in_flag_invalid, 1'b0, in_flag_overflow,
                         in_flag_underflow, in_flag_inexact};
    end else begin
      res_d[wr_ptr_q] = res_q[wr_ptr_q];
    end

    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A retiring head accrues even when the CSR write or a flush lands in the same cycle.
    fflags_d = (fflags_wr_en ? fflags_wr_data : fflags_q) |
               (pop_s ? head_flags_s : 5'b00000);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= 32'h0000_0000;
        tag_q[i] <= {TAG_W{1'b0}};
        flg_q[i] <= 5'b00000;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      fflags_q <= 5'b00000;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
        flg_q[i] <= flg_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_writeback.sv
// Directed bench for fp_mul_writeback: ordering, backpressure, NaN handling,
// fflags accrual/CSR write, flush and asynchronous reset.
module tb_fp_mul_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_tag;
  logic        in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_wr_en;
  logic [4:0]  fflags_wr_data;
  logic [2:0]  count;

  int checks;
  int errors;

  fp_mul_writeback #(.DEPTH(4), .TAG_W(5), .CANON_NAN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_tag(in_tag),
    .in_flag_invalid(in_flag_invalid), .in_flag_overflow(in_flag_overflow),
    .in_flag_underflow(in_flag_underflow), .in_flag_inexact(in_flag_inexact),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
    .fflags(fflags), .fflags_wr_en(fflags_wr_en), .fflags_wr_data(fflags_wr_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted push (in_ready is high whenever this is used); flags as {NV,OF,UF,NX}.
  task automatic push(input logic [4:0] tag, input logic [31:0] res, input logic [3:0] f);
    in_valid          = 1'b1;
    in_tag            = tag;
    in_result         = res;
    in_flag_invalid   = f[3];
    in_flag_overflow  = f[2];
    in_flag_underflow = f[1];
    in_flag_inexact   = f[0];
    tick();
    in_valid = 1'b0;
    in_flag_invalid = 1'b0; in_flag_overflow = 1'b0;
    in_flag_underflow = 1'b0; in_flag_inexact = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (count !== 3'd0) begin $display("FAIL reset_count got %0d exp 0", count); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b exp 0", out_valid); errors++; end
    checks++; if (fflags !== 5'b00000) begin $display("FAIL reset_fflags got %b exp 00000", fflags); errors++; end
    checks++; if (out_result !== 32'h0 || out_tag !== 5'd0 || out_flags !== 5'd0) begin
      $display("FAIL reset_head got %h/%0d/%b exp 0/0/0", out_result, out_tag, out_flags); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo_order();
    push(5'd1, 32'h3F80_0000, 4'b0000);
    checks++; if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
      $display("FAIL latency_one got valid=%b tag=%0d exp 1/1", out_valid, out_tag); errors++; end
    push(5'd2, 32'h4000_0000, 4'b0000);
    push(5'd3, 32'h4040_0000, 4'b0000);
    checks++; if (count !== 3'd3) begin $display("FAIL order_count got %0d exp 3", count); errors++; end
    checks++; if (out_tag !== 5'd1 || out_result !== 32'h3F80_0000) begin
      $display("FAIL order_head got %0d/%h exp 1/3f800000", out_tag, out_result); errors++; end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_tag !== 5'(i)) begin
        $display("FAIL order_retire got valid=%b tag=%0d exp 1/%0d", out_valid, out_tag, i); errors++; end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      $display("FAIL order_drained got valid=%b count=%0d exp 0/0", out_valid, count); errors++; end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 4; i <= 7; i++) push(5'(i), 32'h4100_0000 + 32'(i), 4'b0000);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      $display("FAIL full_state got count=%0d in_ready=%b exp 4/0", count, in_ready); errors++; end
    in_valid = 1'b1; in_tag = 5'd8; in_result = 32'h4100_0008;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL full_no_accept got %b exp 0", in_ready); errors++; end
    tick();
    checks++; if (count !== 3'd3 || out_tag !== 5'd5 || in_ready !== 1'b1) begin
      $display("FAIL full_pop got count=%0d tag=%0d rdy=%b exp 3/5/1", count, out_tag, in_ready); errors++; end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || out_tag !== 5'd6) begin
      $display("FAIL full_push_pop got count=%0d tag=%0d exp 3/6", count, out_tag); errors++; end
    for (int i = 6; i <= 8; i++) begin
      #1;
      checks++; if (out_tag !== 5'(i) || out_result !== 32'h4100_0000 + 32'(i)) begin
        $display("FAIL full_drain got %0d/%h exp %0d", out_tag, out_result, i); errors++; end
      tick();
    end
    checks++; if (count !== 3'd0) begin $display("FAIL full_empty got %0d exp 0", count); errors++; end
    out_ready = 1'b0;
  endtask

  task automatic test_canon_nan();
    push(5'd9,  32'hFFC1_2345, 4'b1000);
    push(5'd10, 32'h7F80_0000, 4'b0000);
    push(5'd11, 32'h7F80_0001, 4'b0000);
    push(5'd12, 32'hFF80_0000, 4'b0000);
    checks++; if (out_result !== 32'h7FC0_0000 || out_flags !== 5'b10000) begin
      $display("FAIL canon_nan got %h/%b exp 7fc00000/10000", out_result, out_flags); errors++; end
    checks++; if (fflags !== 5'b00000) begin $display("FAIL no_accrue_on_push got %b exp 00000", fflags); errors++; end
    out_ready = 1'b1;
    tick();
    checks++; if (out_result !== 32'h7F80_0000 || fflags !== 5'b10000) begin
      $display("FAIL canon_inf got %h/%b exp 7f800000/10000", out_result, fflags); errors++; end
    tick();
    checks++; if (out_result !== 32'h7FC0_0000) begin
      $display("FAIL canon_snan got %h exp 7fc00000", out_result); errors++; end
    tick();
    checks++; if (out_result !== 32'hFF80_0000) begin
      $display("FAIL canon_neg_inf got %h exp ff800000", out_result); errors++; end
    tick();
    out_ready = 1'b0;
    fflags_wr_en = 1'b1; fflags_wr_data = 5'b00000;
    tick();
    fflags_wr_en = 1'b0;
    checks++; if (fflags !== 5'b00000) begin $display("FAIL csr_clear got %b exp 00000", fflags); errors++; end
  endtask

  task automatic test_fflags();
    push(5'd13, 32'h3F00_0000, 4'b0001);
    push(5'd14, 32'h0000_0001, 4'b0011);
    push(5'd15, 32'h7F7F_FFFF, 4'b0100);
    out_ready = 1'b1;
    tick();
    checks++; if (fflags !== 5'b00001) begin $display("FAIL accrue_nx got %b exp 00001", fflags); errors++; end
    tick();
    checks++; if (fflags !== 5'b00011) begin $display("FAIL accrue_uf_nx got %b exp 00011", fflags); errors++; end
    fflags_wr_en = 1'b1; fflags_wr_data = 5'b10000;
    tick();
    fflags_wr_en = 1'b0;
    out_ready = 1'b0;
    checks++; if (fflags !== 5'b10100) begin $display("FAIL csr_write_pop got %b exp 10100", fflags); errors++; end
  endtask

  task automatic test_flush();
    for (int i = 16; i <= 18; i++) push(5'(i), 32'h4200_0000, 4'b0100);
    checks++; if (count !== 3'd3) begin $display("FAIL flush_pre got %0d exp 3", count); errors++; end
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd19;
    #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL flush_in_ready got %b exp 0", in_ready); errors++; end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      $display("FAIL flush_empty got count=%0d valid=%b exp 0/0", count, out_valid); errors++; end
    checks++; if (fflags !== 5'b10100) begin $display("FAIL flush_fflags got %b exp 10100", fflags); errors++; end
    // Flush with a retiring head: the head's flags still accrue.
    fflags_wr_en = 1'b1; fflags_wr_data = 5'b00000;
    tick();
    fflags_wr_en = 1'b0;
    push(5'd20, 32'h4200_0000, 4'b0010);
    push(5'd21, 32'h4200_0000, 4'b0001);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (fflags !== 5'b00010 || count !== 3'd0) begin
      $display("FAIL flush_pop got fflags=%b count=%0d exp 00010/0", fflags, count); errors++; end
  endtask

  task automatic test_async_reset();
    for (int i = 22; i <= 25; i++) push(5'(i), 32'h4300_0000, 4'b1111);
    fflags_wr_en = 1'b1; fflags_wr_data = 5'b11111;
    tick();
    fflags_wr_en = 1'b0;
    checks++; if (count !== 3'd4 || fflags !== 5'b11111) begin
      $display("FAIL async_pre got count=%0d fflags=%b exp 4/11111", count, fflags); errors++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || fflags !== 5'b00000) begin
      $display("FAIL async_reset got count=%0d valid=%b fflags=%b exp 0/0/00000", count, out_valid, fflags); errors++; end
    #3;
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 3'd0 || out_result !== 32'h0) begin
      $display("FAIL async_after got count=%0d result=%h exp 0/0", count, out_result); errors++; end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_result = 32'h0; in_tag = 5'd0;
    in_flag_invalid = 1'b0; in_flag_overflow = 1'b0;
    in_flag_underflow = 1'b0; in_flag_inexact = 1'b0;
    flush = 1'b0; out_ready = 1'b0; fflags_wr_en = 1'b0; fflags_wr_data = 5'b00000;
    test_reset();
    test_fifo_order();
    test_full();
    test_canon_nan();
    test_fflags();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
